// File: rtl/id.sv
// RV32I decode stage: register addresses, ALU operand selection, inst/PC forwarding.
// Define ID_OUT_REG_EN to register every output (1-cycle latency, async active-low reset).
module id (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [4:0]  reg1_raddr_o,
    output logic [4:0]  reg2_raddr_o,
    output logic [4:0]  reg_waddr_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] LINK_INC  = 32'h0000_0004;

    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic [31:0]        imm_u;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_u  = {inst_i[31:12], 12'b0};

    logic [31:0] op1_p0;
    logic [31:0] op2_p0;
    logic [4:0]  ra1_p0;
    logic [4:0]  ra2_p0;
    logic [4:0]  wa_p0;
    logic        ill_p0;

    // Stage p0: combinational decode
    always_comb begin
        op1_p0 = '0;
        op2_p0 = '0;
        ra1_p0 = '0;
        ra2_p0 = '0;
        wa_p0  = '0;
        ill_p0 = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                ra1_p0 = rs1;
                wa_p0  = rd;
                op1_p0 = reg1_rdata_i;
                // Shift amount is zero-extended; EX looks at funct7 in inst_o for SRAI.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    op2_p0 = {27'b0, inst_i[24:20]};
                else
                    op2_p0 = imm_i;
            end
            OPC_OP: begin
                ra1_p0 = rs1;
                ra2_p0 = rs2;
                wa_p0  = rd;
                op1_p0 = reg1_rdata_i;
                op2_p0 = reg2_rdata_i;
            end
            OPC_LOAD: begin
                ra1_p0 = rs1;
                wa_p0  = rd;
                op1_p0 = reg1_rdata_i;
                op2_p0 = imm_i;
            end
            OPC_STORE: begin
                ra1_p0 = rs1;
                ra2_p0 = rs2;
                op1_p0 = reg1_rdata_i;
                op2_p0 = imm_s;
            end
            OPC_BRANCH: begin
                ra1_p0 = rs1;
                ra2_p0 = rs2;
                op1_p0 = reg1_rdata_i;
                op2_p0 = reg2_rdata_i;
            end
            OPC_LUI: begin
                wa_p0  = rd;
                op1_p0 = imm_u;
            end
            OPC_AUIPC: begin
                wa_p0  = rd;
                op1_p0 = inst_addr_i;
                op2_p0 = imm_u;
            end
            OPC_JAL: begin
                wa_p0  = rd;
                op1_p0 = inst_addr_i;
                op2_p0 = LINK_INC;
            end
            OPC_JALR: begin
                ra1_p0 = rs1;
                wa_p0  = rd;
                op1_p0 = inst_addr_i;
                op2_p0 = LINK_INC;
            end
            default: ill_p0 = 1'b1;
        endcase
    end

`ifdef ID_OUT_REG_EN
    // Stage p1: registered outputs, NOP bubble while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_o        <= '0;
            op2_o        <= '0;
            inst_o       <= INST_NOP;
            inst_addr_o  <= '0;
            reg1_raddr_o <= '0;
            reg2_raddr_o <= '0;
            reg_waddr_o  <= '0;
            illegal_o    <= 1'b0;
        end else begin
            op1_o        <= op1_p0;
            op2_o        <= op2_p0;
            inst_o       <= inst_i;
            inst_addr_o  <= inst_addr_i;
            reg1_raddr_o <= ra1_p0;
            reg2_raddr_o <= ra2_p0;
            reg_waddr_o  <= wa_p0;
            illegal_o    <= ill_p0;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    assign op1_o        = op1_p0;
    assign op2_o        = op2_p0;
    assign inst_o       = inst_i;
    assign inst_addr_o  = inst_addr_i;
    assign reg1_raddr_o = ra1_p0;
    assign reg2_raddr_o = ra2_p0;
    assign reg_waddr_o  = wa_p0;
    assign illegal_o    = ill_p0;
`endif

endmodule

// File: tb/tb_id.sv
// Table-driven bench for the id decode stage, scoreboard-checked; covers both build variants.
module tb_id;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] reg1_rdata_i = '0;
    logic [31:0] reg2_rdata_i = '0;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [4:0]  reg1_raddr_o;
    logic [4:0]  reg2_raddr_o;
    logic [4:0]  reg_waddr_o;
    logic        illegal_o;

    id dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .reg1_rdata_i (reg1_rdata_i),
        .reg2_rdata_i (reg2_rdata_i),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .reg1_raddr_o (reg1_raddr_o),
        .reg2_raddr_o (reg2_raddr_o),
        .reg_waddr_o  (reg_waddr_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(string name, logic [31:0] inst, logic [31:0] addr,
                                logic [31:0] op1, logic [31:0] op2, logic [4:0] ra1,
                                logic [4:0] ra2, logic [4:0] wa, logic ill);
        vec_t v;
        v.name = name; v.inst = inst; v.addr = addr;
        v.r1 = 32'h42; v.r2 = 32'h69;
        v.op1 = op1; v.op2 = op2; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.ill = ill;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        inst_i = v.inst;
        inst_addr_i = v.addr;
        reg1_rdata_i = v.r1;
        reg2_rdata_i = v.r2;
        sb.push_back(v);
    endtask

    task automatic compare_out();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".op1"},   op1_o, e.op1);
        chk({e.name, ".op2"},   op2_o, e.op2);
        chk({e.name, ".inst"},  inst_o, e.inst);
        chk({e.name, ".addr"},  inst_addr_o, e.addr);
        chk({e.name, ".raddr1"}, {27'b0, reg1_raddr_o}, {27'b0, e.ra1});
        chk({e.name, ".raddr2"}, {27'b0, reg2_raddr_o}, {27'b0, e.ra2});
        chk({e.name, ".waddr"},  {27'b0, reg_waddr_o}, {27'b0, e.wa});
        chk({e.name, ".illegal"}, {31'b0, illegal_o}, {31'b0, e.ill});
    endtask

    task automatic check_reset(string name);
        chk({name, ".op1"},  op1_o, 32'h0);
        chk({name, ".op2"},  op2_o, 32'h0);
        chk({name, ".inst"}, inst_o, 32'h13);
        chk({name, ".addr"}, inst_addr_o, 32'h0);
        chk({name, ".addrs"}, {17'b0, reg1_raddr_o, reg2_raddr_o, reg_waddr_o}, 32'h0);
        chk({name, ".illegal"}, {31'b0, illegal_o}, 32'h0);
    endtask

    task automatic step(vec_t v);
`ifdef ID_OUT_REG_EN
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
`else
        drive(v);
        #2;
`endif
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t addi;
        addi = mk("addi", 32'hfff08013, 32'h123, 32'h42, 32'hffffffff, 5'd1, 5'd0, 5'd0, 1'b0);

        vecs.push_back(mk("slti",  32'h0021a113, 32'h123, 32'h42, 32'h2,        5'd3,  5'd0, 5'd2,  1'b0));
        vecs.push_back(mk("sltiu", 32'hffd2b213, 32'h123, 32'h42, 32'hfffffffd, 5'd5,  5'd0, 5'd4,  1'b0));
        vecs.push_back(mk("xori",  32'h0043c313, 32'h123, 32'h42, 32'h4,        5'd7,  5'd0, 5'd6,  1'b0));
        vecs.push_back(mk("ori",   32'hffb4e413, 32'h123, 32'h42, 32'hfffffffb, 5'd9,  5'd0, 5'd8,  1'b0));
        vecs.push_back(mk("andi",  32'h0065f513, 32'h123, 32'h42, 32'h6,        5'd11, 5'd0, 5'd10, 1'b0));
        vecs.push_back(mk("slli",  32'h00769613, 32'h123, 32'h42, 32'h7,        5'd13, 5'd0, 5'd12, 1'b0));
        vecs.push_back(mk("srli",  32'h0087d713, 32'h123, 32'h42, 32'h8,        5'd15, 5'd0, 5'd14, 1'b0));
        vecs.push_back(mk("illegal0", 32'h00000000, 32'h123, 32'h0, 32'h0,     5'd0,  5'd0, 5'd0,  1'b1));
        vecs.push_back(mk("srai",  32'h40315093, 32'h123, 32'h42, 32'h3,        5'd2,  5'd0, 5'd1,  1'b0));
        vecs.push_back(mk("add",   32'h002081b3, 32'h123, 32'h42, 32'h69,       5'd1,  5'd2, 5'd3,  1'b0));
        vecs.push_back(mk("jal",   32'h0000006f, 32'h123, 32'h123, 32'h4,       5'd0,  5'd0, 5'd0,  1'b0));
        vecs.push_back(mk("lui",   32'h123450b7, 32'h123, 32'h12345000, 32'h0,  5'd0,  5'd0, 5'd1,  1'b0));
        vecs.push_back(mk("lw",    32'hff81a203, 32'h123, 32'h42, 32'hfffffff8, 5'd3,  5'd0, 5'd4,  1'b0));
        vecs.push_back(mk("sw",    32'h0020a423, 32'h123, 32'h42, 32'h8,        5'd1,  5'd2, 5'd0,  1'b0));
        vecs.push_back(mk("sw_neg", 32'hfe20ae23, 32'h123, 32'h42, 32'hfffffffc, 5'd1, 5'd2, 5'd0,  1'b0));
        vecs.push_back(mk("illegal1", 32'hffffffff, 32'h123, 32'h0, 32'h0,     5'd0,  5'd0, 5'd0,  1'b1));
        vecs.push_back(mk("beq",   32'h00208063, 32'h123, 32'h42, 32'h69,       5'd1,  5'd2, 5'd0,  1'b0));
        vecs.push_back(mk("auipc", 32'habcde297, 32'h80000040, 32'h80000040, 32'habcde000, 5'd0, 5'd0, 5'd5, 1'b0));
        vecs.push_back(mk("jalr",  32'h000100e7, 32'h00000200, 32'h00000200, 32'h4, 5'd2, 5'd0, 5'd1, 1'b0));

`ifdef ID_OUT_REG_EN
        inst_i = addi.inst; inst_addr_i = addi.addr;
        reg1_rdata_i = addi.r1; reg2_rdata_i = addi.r2;
        #3;
        check_reset("rst_hold");
        @(posedge clk); #1;
        check_reset("rst_hold_edge");
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(addi);
        #1;
        check_reset("pre_first_edge");
        @(posedge clk); #1;
        compare_out();
`else
        drive(addi);
        #2;
        compare_out();
        rst_n = 1'b1;
        step(addi);
`endif

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

`ifdef ID_OUT_REG_EN
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(vecs[0]);
`else
        rst_n = 1'b0;
        step(vecs[1]);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id.md
Name: id

Overview:
- RV32I instruction-decode stage of the nanosoc pipeline, sitting between IF/ID and ID/EX.
- Extracts register-file read addresses and the destination address from the fetched instruction.
- Selects and forms the two ALU operands (register data, sign-extended immediate, PC, constants).
- Passes the instruction word and its address downstream.

Parameters:
- none

Ports:
- clk  input  1  pipeline clock; used only when ID_OUT_REG_EN is defined
- rst_n  input  1  asynchronous active-low reset; used only when ID_OUT_REG_EN is defined
- inst_i  input  32  instruction word from IF/ID
- inst_addr_i  input  32  address (PC) of inst_i
- reg1_rdata_i  input  32  register-file data for reg1_raddr_o
- reg2_rdata_i  input  32  register-file data for reg2_raddr_o
- op1_o  output  32  ALU operand 1
- op2_o  output  32  ALU operand 2
- inst_o  output  32  instruction word forwarded to EX
- inst_addr_o  output  32  instruction address forwarded to EX
- reg1_raddr_o  output  5  rs1 read address
- reg2_raddr_o  output  5  rs2 read address
- reg_waddr_o  output  5  rd write address
- illegal_o  output  1  opcode not recognised

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Default build is purely combinational, zero latency; clk/rst_n are unused.
- Field extraction: opcode = inst[6:0], rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20].
- inst_o = inst_i and inst_addr_o = inst_addr_i, always.
- Unused read/write addresses are driven to 0.
- rd = x0 is still reported as 0 on reg_waddr_o; write suppression is not done here.
- Immediates: I = sext(inst[31:20]); S = sext({inst[31:25], inst[11:7]}); U = {inst[31:12], 12'b0}.
- 0010011 OP-IMM: raddr1 = rs1, raddr2 = 0, waddr = rd, op1 = reg1_rdata.
  - funct3 001/101 (shifts): op2 = {27'b0, inst[24:20]}; EX reads funct7 from inst_o to tell SRAI.
  - All other funct3: op2 = I-imm.
- 0110011 OP: raddr1 = rs1, raddr2 = rs2, waddr = rd, op1 = reg1_rdata, op2 = reg2_rdata.
- 0000011 LOAD: raddr1 = rs1, raddr2 = 0, waddr = rd, op1 = reg1_rdata, op2 = I-imm.
- 0100011 STORE: raddr1 = rs1, raddr2 = rs2, waddr = 0, op1 = reg1_rdata, op2 = S-imm.
- 1100011 BRANCH: raddr1 = rs1, raddr2 = rs2, waddr = 0, op1 = reg1_rdata, op2 = reg2_rdata; EX forms the target from inst_o.
- 0110111 LUI: raddr1 = 0, raddr2 = 0, waddr = rd, op1 = U-imm, op2 = 0.
- 0010111 AUIPC: raddr1 = 0, raddr2 = 0, waddr = rd, op1 = inst_addr_i, op2 = U-imm.
- 1101111 JAL: raddr1 = 0, raddr2 = 0, waddr = rd, op1 = inst_addr_i, op2 = 32'h4 (link value).
- 1100111 JALR: raddr1 = rs1, raddr2 = 0, waddr = rd, op1 = inst_addr_i, op2 = 32'h4.
- Any other opcode: illegal_o = 1; all addresses and operands 0; inst and addr still forwarded.
- illegal_o = 0 for every recognised opcode.
- Within a recognised opcode, funct3/funct7 are not validated.

Optional Feature:
- Macro ID_OUT_REG_EN.
- Defined:
  - All outputs are registered on posedge clk; latency 1 cycle; no stall or flush inputs.
  - Inputs are sampled the same cycle; reg1_rdata_i/reg2_rdata_i must be valid with inst_i (combinational register file).
  - While rst_n = 0 (asynchronous): inst_o = 32'h00000013 (NOP), every other output 0, illegal_o = 0.
  - First edge after reset release loads the decoded values.
- Undefined: combinational behaviour as above; clk/rst_n ignored.

Test Plan:
- Common inputs for the first five lines: reg1_rdata_i = 0x42, reg2_rdata_i = 0x69, inst_addr_i = 0x123.
- inst = 0xfff08013 (addi x0,x1,-1) -> op1 = 0x42, op2 = 0xffffffff, raddr1 = 1, raddr2 = 0, waddr = 0.
- 0x0021a113 (slti) -> op2 = 0x2, raddr1 = 3, waddr = 2.
- 0xffd2b213 (sltiu) -> op2 = 0xfffffffd, raddr1 = 5, waddr = 4.
- 0x0043c313 (xori) -> op2 = 0x4, raddr1/waddr = 7/6.
- 0xffb4e413 (ori) -> op2 = 0xfffffffb, raddr1/waddr = 9/8.
- 0x0065f513 (andi) -> op2 = 0x6, raddr1/waddr = 0xb/0xa.
- 0x00769613 (slli) -> op2 = 0x7, raddr1/waddr = 0xd/0xc.
- 0x0087d713 (srli) -> op2 = 0x8, raddr1/waddr = 0xf/0xe.
- 0x002081b3 (add x3,x1,x2) -> op2 = 0x69, raddr2 = 2, waddr = 3.
- 0x0000006f (jal), inst_addr_i = 0x123 -> op1 = 0x123, op2 = 4.
- 0x123450b7 (lui) -> op1 = 0x12345000, op2 = 0.
- 0x00000000 -> illegal_o = 1, op1 = op2 = 0.
- With ID_OUT_REG_EN: hold rst_n = 0 -> inst_o = 0x13, others 0.
- Release reset, apply addi x0,x1,-1 -> outputs update only after the next posedge.
- Assert rst_n mid-run -> immediate return to reset values without a clock edge.
